pixel_stream_packer: RTL and testbench

//  Downstream of the pixel generator. Accepts one 24-bit RGB pixel per handshake with sof/eol markers.

---
 rtl/pixel_stream_pkg.sv | 43 ++++
 rtl/pixel_stream_packer_axis_out_reg.sv | 31 +++
 rtl/pixel_stream_packer.sv | 175 +++++++++++++++++
 tb/tb_pixel_stream_packer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_stream_pkg.sv
// Shared types and constants for the 24-bit RGB to 32-bit AXI-Stream pixel packer.
package pixel_stream_pkg;

  // Packed so that b occupies bits [7:0]: this is the byte that goes onto the stream first.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [2:0] {
    PH0,
    PH1,
    PH2,
    PH3,
    FLUSH
  } pack_state_t;

  // One beat of the output register: {tuser, tlast, tdata}.
  typedef struct packed {
    logic        user;
    logic        last;
    logic [31:0] data;
  } axis_word_t;

  localparam logic [3:0] AXI_TKEEP_ALL = 4'hF;

  // Builds the final word of a line: the low nbytes come from the leftover bytes,
  // every byte above them is filled with the pad value.
  function automatic logic [31:0] pad_word(input logic [23:0] leftover,
                                           input logic [1:0]  nbytes,
                                           input logic [7:0]  pad);
    logic [31:0] src;
    logic [31:0] word;
    src  = {8'h00, leftover};
    word = '0;
    for (int i = 0; i < 4; i++) begin
      word[8*i +: 8] = (i < int'(nbytes)) ? src[8*i +: 8] : pad;
    end
    return word;
  endfunction

endpackage

// File: rtl/pixel_stream_packer_axis_out_reg.sv
// Single-stage AXI-Stream output register holding {tuser, tlast, tdata} with valid/ready.
module axis_out_reg
  import pixel_stream_pkg::*;
(
  input  logic       sysclk,
  input  logic       reset,
  input  logic       load,
  input  axis_word_t word_in,
  input  logic       tready,
  output logic       tvalid,
  output axis_word_t word,
  output logic       can_load
);

  // The register may take a new word when empty or when its current word leaves this cycle.
  assign can_load = !tvalid || tready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      tvalid <= 1'b0;
      word   <= '0;
    end else if (load) begin
      tvalid <= 1'b1;
      word   <= word_in;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/pixel_stream_packer.sv
// Packs 24-bit RGB pixels four at a time into three 32-bit AXI-Stream words.
// Optional sticky line-length checker enabled by defining PIXEL_PACKER_ERR_EN.
module pixel_stream_packer
  import pixel_stream_pkg::*;
#(
  parameter int         LINE_PIXELS = 640,
  parameter logic [7:0] PAD_BYTE    = 8'h00
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        sof,
  input  logic        eol,
  input  logic        valid,
  output logic        in_stream_ready,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  output logic        out_stream_tuser,
  output logic        out_stream_tvalid,
  input  logic        out_stream_tready,
  output logic        pack_err
);

  if (LINE_PIXELS < 1 || LINE_PIXELS > 2047) begin : g_bad_line_pixels
    $error("LINE_PIXELS must fit the 11-bit pixel-in-line counter");
  end

  pack_state_t state;
  rgb_t        pixel;
  logic [23:0] rem;          // leftover bytes of the group, right-aligned
  logic [1:0]  flush_bytes;  // number of valid bytes in rem when flushing
  logic        user_pend;    // sof seen, not yet carried by an emitted word
  logic        out_free;
  logic        accept;
  logic        emit;
  axis_word_t  emit_word;
  axis_word_t  out_word;

  assign pixel = '{r: r, g: g, b: b};

  assign in_stream_ready = (state != FLUSH) && ((state == PH0) || out_free);
  assign accept          = valid && in_stream_ready;

  // A sof pixel in PH1..PH3 restarts the group, so nothing is emitted for it.
  // NOTE: always_comb assigns defaults first so no path leaves a signal unassigned (no latch).
  always_comb begin
    emit      = 1'b0;
    emit_word = '0;
    case (state)
      PH1: begin
        emit           = accept && !sof;
        emit_word.data = {pixel[7:0], rem};
      end
      PH2: begin
        emit           = accept && !sof;
        emit_word.data = {pixel[15:0], rem[15:0]};
      end
      PH3: begin
        emit           = accept && !sof;
        emit_word.data = {pixel, rem[7:0]};
        emit_word.last = eol;
      end
      FLUSH: begin
        emit           = out_free;
        emit_word.data = pad_word(rem, flush_bytes, PAD_BYTE);
        emit_word.last = 1'b1;
      end
      default: ;
    endcase
    emit_word.user = user_pend;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state       <= PH0;
      rem         <= '0;
      flush_bytes <= '0;
      user_pend   <= 1'b0;
    end else begin
      if (emit) user_pend <= 1'b0;
      case (state)
        PH0: begin
          if (accept) begin
            rem         <= pixel;
            user_pend   <= sof;
            flush_bytes <= 2'd3;
            state       <= eol ? FLUSH : PH1;
          end
        end
        PH1, PH2, PH3: begin
          if (accept && sof) begin
            rem         <= pixel;
            user_pend   <= 1'b1;
            flush_bytes <= 2'd3;
            state       <= eol ? FLUSH : PH1;
          end else if (accept) begin
            case (state)
              PH1: begin
                rem         <= {8'h00, pixel[23:8]};
                flush_bytes <= 2'd2;
                state       <= eol ? FLUSH : PH2;
              end
              PH2: begin
                rem         <= {16'h0000, pixel[23:16]};
                flush_bytes <= 2'd1;
                state       <= eol ? FLUSH : PH3;
              end
              default: begin
                rem   <= '0;
                state <= PH0;
              end
            endcase
          end
        end
        FLUSH: begin
          if (out_free) begin
            rem   <= '0;
            state <= PH0;
          end
        end
        default: state <= PH0;
      endcase
    end
  end

  axis_out_reg u_out_reg (
    .sysclk   (sysclk),
    .reset    (reset),
    .load     (emit),
    .word_in  (emit_word),
    .tready   (out_stream_tready),
    .tvalid   (out_stream_tvalid),
    .word     (out_word),
    .can_load (out_free)
  );

  assign out_stream_tdata = out_word.data;
  assign out_stream_tlast = out_word.last;
  assign out_stream_tuser = out_word.user;
  assign out_stream_tkeep = AXI_TKEEP_ALL;

`ifdef PIXEL_PACKER_ERR_EN
  localparam logic [10:0] LINE_PIXELS_W = 11'(LINE_PIXELS);

  logic [10:0] px_count;
  logic [10:0] px_count_next;
  logic        err_q;

  // A sof pixel starts a fresh count and is itself pixel number one.
  assign px_count_next = (sof ? 11'd0 : px_count) + 11'd1;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      px_count <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      if (eol) begin
        px_count <= '0;
        if (px_count_next != LINE_PIXELS_W) err_q <= 1'b1;
      end else begin
        px_count <= px_count_next;
        if (px_count_next == LINE_PIXELS_W) err_q <= 1'b1;
      end
    end
  end

  assign pack_err = err_q;
`else
  assign pack_err = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Scoreboard bench for pixel_stream_packer: stimulus pushes expected words, a monitor pops on handshake.
module tb_pixel_stream_packer;

`ifdef PIXEL_PACKER_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        sysclk = 1'b0;
  logic        reset;
  logic [7:0]  r, g, b;
  logic        sof, eol, valid;
  logic        in_stream_ready;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast;
  logic        out_stream_tuser;
  logic        out_stream_tvalid;
  logic        out_stream_tready = 1'b0;
  logic        pack_err;

  int tready_mode = 1;  // 0 = low, 1 = high, 2 = toggle every cycle

  always #5 sysclk = ~sysclk;

  pixel_stream_packer dut (
    .sysclk            (sysclk),
    .reset             (reset),
    .r                 (r),
    .g                 (g),
    .b                 (b),
    .sof               (sof),
    .eol               (eol),
    .valid             (valid),
    .in_stream_ready   (in_stream_ready),
    .out_stream_tdata  (out_stream_tdata),
    .out_stream_tkeep  (out_stream_tkeep),
    .out_stream_tlast  (out_stream_tlast),
    .out_stream_tuser  (out_stream_tuser),
    .out_stream_tvalid (out_stream_tvalid),
    .out_stream_tready (out_stream_tready),
    .pack_err          (pack_err)
  );

  always begin
    @(posedge sysclk);
    #1;
    case (tready_mode)
      0:       out_stream_tready = 1'b0;
      1:       out_stream_tready = 1'b1;
      default: out_stream_tready = ~out_stream_tready;
    endcase
  end

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        user;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] bq[$];
  logic       m_user = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic push_exp(input logic [31:0] data, input logic last, input logic user);
    exp_t e;
    e.data = data;
    e.last = last;
    e.user = user;
    exp_q.push_back(e);
  endtask

  // Reference model: a plain byte FIFO in stream order (b, g, r), padded with zeros at end of line.
  task automatic model_px(input logic [23:0] px, input logic s, input logic e);
    logic [31:0] w;
    if (s) begin
      bq.delete();
      m_user = 1'b1;
    end
    bq.push_back(px[7:0]);
    bq.push_back(px[15:8]);
    bq.push_back(px[23:16]);
    if (e) while (bq.size() % 4 != 0) bq.push_back(8'h00);
    while (bq.size() >= 4) begin
      w = {bq[3], bq[2], bq[1], bq[0]};
      repeat (4) void'(bq.pop_front());
      push_exp(w, e && (bq.size() == 0), m_user);
      m_user = 1'b0;
    end
  endtask

  // Monitor: a word seen valid & ready at the falling edge is handed off on the next rising edge.
  logic        prev_stall = 1'b0;
  logic [33:0] prev_word;
  always @(negedge sysclk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_tvalid_held", {31'd0, out_stream_tvalid}, 32'd1);
        check("stall_tdata_stable", out_stream_tdata, prev_word[31:0]);
        check("stall_flags_stable", {30'd0, out_stream_tuser, out_stream_tlast},
              {30'd0, prev_word[33:32]});
      end
      if (out_stream_tvalid && out_stream_tready) begin
        if (exp_q.size() == 0) begin
          fail($sformatf("unexpected_word: got 0x%08h, expected no word", out_stream_tdata));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word_tdata", out_stream_tdata, e.data);
          check("word_tlast", {31'd0, out_stream_tlast}, {31'd0, e.last});
          check("word_tuser", {31'd0, out_stream_tuser}, {31'd0, e.user});
          check("word_tkeep", {28'd0, out_stream_tkeep}, 32'hF);
        end
      end
      prev_stall = out_stream_tvalid && !out_stream_tready;
      prev_word  = {out_stream_tuser, out_stream_tlast, out_stream_tdata};
    end
  end

  // Presents one pixel and holds it until accepted (bounded), leaving the bench at rising edge + 1.
  task automatic send(input logic [23:0] px, input logic s, input logic e);
    int t;
    {r, g, b} = px;
    sof   = s;
    eol   = e;
    valid = 1'b1;
    t = 0;
    do begin
      @(negedge sysclk);
      t++;
    end while (!in_stream_ready && t < 200);
    if (!in_stream_ready) fail("accept_timeout");
    @(posedge sysclk);
    #1;
    valid = 1'b0;
    sof   = 1'b0;
    eol   = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge sysclk);
      t++;
    end
    if (exp_q.size() != 0) fail($sformatf("drain_timeout: %0d words outstanding", exp_q.size()));
    repeat (3) @(posedge sysclk);
    #1;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    valid = 1'b0;
    {r, g, b} = '0;
    sof = 1'b0;
    eol = 1'b0;
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    check("reset_tvalid", {31'd0, out_stream_tvalid}, 32'd0);
    check("reset_tdata", out_stream_tdata, 32'd0);
    check("reset_flags", {30'd0, out_stream_tuser, out_stream_tlast}, 32'd0);
    check("reset_ready", {31'd0, in_stream_ready}, 32'd1);
    check("reset_pack_err", {31'd0, pack_err}, 32'd0);
    @(posedge sysclk);
    #1;
    reset = 1'b0;

    // Full group of four, eol on p3: three words, tlast only on the third.
    push_exp(32'h0300_0102, 1'b0, 1'b1);
    push_exp(32'h0304_0102, 1'b0, 1'b0);
    push_exp(32'h0304_0502, 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) send({8'(n), 8'(n + 1), 8'(n + 2)}, n == 0, n == 3);
    drain();
    check("short_line_pack_err", {31'd0, pack_err}, {31'd0, ERR_EN});

    // eol on p1: W0 then padded flush word, input stalled for one cycle.
    push_exp(32'h33AA_BBCC, 1'b0, 1'b0);
    push_exp(32'h0000_1122, 1'b1, 1'b0);
    send(24'hAABBCC, 1'b0, 1'b0);
    send(24'h112233, 1'b0, 1'b1);
    @(negedge sysclk);
    check("flush_ready_low", {31'd0, in_stream_ready}, 32'd0);
    @(negedge sysclk);
    check("after_flush_ready", {31'd0, in_stream_ready}, 32'd1);
    drain();

    // eol on p0 and on p2.
    push_exp(32'h0044_5566, 1'b1, 1'b0);
    send(24'h445566, 1'b0, 1'b1);
    push_exp(32'h0601_0203, 1'b0, 1'b0);
    push_exp(32'h0809_0405, 1'b0, 1'b0);
    push_exp(32'h0000_0007, 1'b1, 1'b0);
    send(24'h010203, 1'b0, 1'b0);
    send(24'h040506, 1'b0, 1'b0);
    send(24'h070809, 1'b0, 1'b1);
    drain();

    // Sink ready toggling every cycle through a 17-pixel line.
    tready_mode = 2;
    for (int i = 0; i < 17; i++) begin
      model_px(24'(i * 24'h030507 + 24'h10), i == 0, i == 16);
      send(24'(i * 24'h030507 + 24'h10), i == 0, i == 16);
    end
    drain();
    tready_mode = 1;
    @(posedge sysclk);
    #1;

    // Three full 640-pixel lines of a frame; sof on the very first pixel only.
    for (int ln = 0; ln < 3; ln++) begin
      for (int i = 0; i < 640; i++) begin
        model_px({8'(ln), 8'(i), 8'(i >> 8) ^ 8'h5A}, (ln == 0) && (i == 0), i == 639);
        send({8'(ln), 8'(i), 8'(i >> 8) ^ 8'h5A}, (ln == 0) && (i == 0), i == 639);
      end
    end
    drain();

    // Reset while a word is pending and the packer sits in PH2.
    tready_mode = 0;
    repeat (2) @(posedge sysclk);
    #1;
    send(24'hAABBCC, 1'b1, 1'b0);
    send(24'h112233, 1'b0, 1'b0);
    @(negedge sysclk);
    check("pre_reset_tvalid", {31'd0, out_stream_tvalid}, 32'd1);
    @(posedge sysclk);
    #1;
    reset = 1'b1;
    @(posedge sysclk);
    #1;
    reset = 1'b0;
    @(negedge sysclk);
    check("post_reset_tvalid", {31'd0, out_stream_tvalid}, 32'd0);
    check("post_reset_ready", {31'd0, in_stream_ready}, 32'd1);
    check("post_reset_pack_err", {31'd0, pack_err}, 32'd0);
    tready_mode = 1;
    @(posedge sysclk);
    #1;
    push_exp(32'h33AA_BBCC, 1'b0, 1'b1);
    push_exp(32'h0000_1122, 1'b1, 1'b0);
    send(24'hAABBCC, 1'b1, 1'b0);
    send(24'h112233, 1'b0, 1'b1);
    drain();
    check("final_pack_err", {31'd0, pack_err}, {31'd0, ERR_EN});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
